// File: rtl/mandel_row_dispatcher.sv
// On-demand row distributor for the Mandelbrot solvers: hands out frame rows
// round-robin over per-solver request/grant handshakes and times each frame.
module mandel_row_dispatcher #(
  parameter int NUM_SOLVERS = 4,
  parameter int COORD_W     = 27,
  parameter int ROWS        = 480,
  parameter int ROW_W       = 9,
  parameter int CYCLE_W     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COORD_W-1:0]     init_x,
  input  logic [COORD_W-1:0]     init_y,
  input  logic [COORD_W-1:0]     y_incr,
  input  logic [NUM_SOLVERS-1:0] row_req,
  input  logic [NUM_SOLVERS-1:0] row_done,
  output logic [NUM_SOLVERS-1:0] row_valid,
  output logic [ROW_W-1:0]       row_index,
  output logic [COORD_W-1:0]     row_x0,
  output logic [COORD_W-1:0]     row_ci,
  output logic                   flush,
  output logic                   busy,
  output logic                   done,
  output logic [CYCLE_W-1:0]     cycle_count
);

  localparam int PTR_W = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
  // One extra bit so the row counter can hold ROWS even when ROWS == 2**ROW_W.
  localparam logic [ROW_W:0] ROWS_C = (ROW_W+1)'(ROWS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [COORD_W-1:0]     x0_lat_q, x0_lat_d;
  logic [COORD_W-1:0]     y_incr_q, y_incr_d;
  logic [COORD_W-1:0]     ci_acc_q, ci_acc_d;
  logic [ROW_W:0]         next_row_q, next_row_d;
  logic [NUM_SOLVERS-1:0] outstanding_q, outstanding_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [NUM_SOLVERS-1:0] row_valid_q, row_valid_d;
  logic [ROW_W-1:0]       row_index_q, row_index_d;
  logic [COORD_W-1:0]     row_x0_q, row_x0_d;
  logic [COORD_W-1:0]     row_ci_q, row_ci_d;
  logic [CYCLE_W-1:0]     cycle_count_q, cycle_count_d;

  logic [NUM_SOLVERS-1:0] eligible;
  logic [NUM_SOLVERS-1:0] grant_oh;
  logic [PTR_W-1:0]       grant_idx;
  logic                   grant_vld;
  logic                   can_grant;

  assign flush       = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD) || (state_q == S_DISPATCH) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign row_valid   = row_valid_q;
  assign row_index   = row_index_q;
  assign row_x0      = row_x0_q;
  assign row_ci      = row_ci_q;
  assign cycle_count = cycle_count_q;

  // Round-robin search: first eligible solver at or after the pointer.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    eligible  = row_req & ~outstanding_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    idx       = '0;
    for (int j = 0; j < NUM_SOLVERS; j++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(j);
      if (sum >= (PTR_W+1)'(NUM_SOLVERS)) sum = sum - (PTR_W+1)'(NUM_SOLVERS);
      idx = sum[PTR_W-1:0];
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    can_grant = (state_q == S_DISPATCH) && (next_row_q < ROWS_C) && !start && grant_vld;
    grant_oh  = '0;
    grant_oh[grant_idx] = can_grant;
  end

  always_comb begin
    state_d       = state_q;
    x0_lat_d      = x0_lat_q;
    y_incr_d      = y_incr_q;
    ci_acc_d      = ci_acc_q;
    next_row_d    = next_row_q;
    outstanding_d = outstanding_q;
    ptr_d         = ptr_q;
    row_valid_d   = '0;
    row_index_d   = row_index_q;
    row_x0_d      = row_x0_q;
    row_ci_d      = row_ci_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      S_LOAD:     state_d = S_DISPATCH;
      S_DISPATCH: if (next_row_q == ROWS_C) state_d = S_DRAIN;
      S_DRAIN:    if (outstanding_q == '0) state_d = S_DONE;
      default:    state_d = state_q;
    endcase

    if (state_q != S_LOAD) outstanding_d = outstanding_q & ~row_done;
    if (busy && (cycle_count_q != '1)) cycle_count_d = cycle_count_q + 1'b1;

    if (can_grant) begin
      outstanding_d = outstanding_d | grant_oh;
      row_valid_d   = grant_oh;
      row_index_d   = next_row_q[ROW_W-1:0];
      row_x0_d      = x0_lat_q;
      row_ci_d      = ci_acc_q;
      next_row_d    = next_row_q + 1'b1;
      ci_acc_d      = ci_acc_q + y_incr_q;
      ptr_d         = (grant_idx == PTR_W'(NUM_SOLVERS-1)) ? '0 : grant_idx + 1'b1;
    end

    // Start from any state restarts the frame; in-flight rows are forgotten.
    if (start) begin
      state_d       = S_LOAD;
      x0_lat_d      = init_x;
      y_incr_d      = y_incr;
      ci_acc_d      = init_y;
      next_row_d    = '0;
      outstanding_d = '0;
      ptr_d         = '0;
      cycle_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      x0_lat_q      <= '0;
      y_incr_q      <= '0;
      ci_acc_q      <= '0;
      next_row_q    <= '0;
      outstanding_q <= '0;
      ptr_q         <= '0;
      row_valid_q   <= '0;
      row_index_q   <= '0;
      row_x0_q      <= '0;
      row_ci_q      <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      x0_lat_q      <= x0_lat_d;
      y_incr_q      <= y_incr_d;
      ci_acc_q      <= ci_acc_d;
      next_row_q    <= next_row_d;
      outstanding_q <= outstanding_d;
      ptr_q         <= ptr_d;
      row_valid_q   <= row_valid_d;
      row_index_q   <= row_index_d;
      row_x0_q      <= row_x0_d;
      row_ci_q      <= row_ci_d;
      cycle_count_q <= cycle_count_d;
    end
  end

endmodule

// File: tb/tb_mandel_row_dispatcher.sv
// Bench for mandel_row_dispatcher: directed scenarios plus randomized solver
// traffic, every cycle compared against a frame-level behavioural model.
module tb_mandel_row_dispatcher;
  localparam int NS = 4, CW = 27, ROWS = 8, ROW_W = 4, CYW = 6;
  localparam int MAXCC = (1 << CYW) - 1;

  logic clk = 1'b0;
  logic reset, start;
  logic [CW-1:0] init_x, init_y, y_incr;
  logic [NS-1:0] row_req, row_done, row_valid;
  logic [ROW_W-1:0] row_index;
  logic [CW-1:0] row_x0, row_ci;
  logic flush, busy, done;
  logic [CYW-1:0] cycle_count;

  always #5 clk = ~clk;

  mandel_row_dispatcher #(.NUM_SOLVERS(NS), .COORD_W(CW), .ROWS(ROWS), .ROW_W(ROW_W), .CYCLE_W(CYW)) dut (
    .clk(clk), .reset(reset), .start(start), .init_x(init_x), .init_y(init_y), .y_incr(y_incr),
    .row_req(row_req), .row_done(row_done), .row_valid(row_valid), .row_index(row_index),
    .row_x0(row_x0), .row_ci(row_ci), .flush(flush), .busy(busy), .done(done), .cycle_count(cycle_count));

  int n_vec = 0, n_bad = 0;

  typedef enum {P_IDLE, P_LOAD, P_DISP, P_DRAIN, P_DONE} phase_t;
  phase_t m_ph = P_IDLE;
  bit [NS-1:0] m_out = '0;
  int m_ptr = 0, m_next = 0, m_cc = 0, m_idx = 0;
  logic [CW-1:0] m_ix = '0, m_iy = '0, m_inc = '0, m_x0 = '0, m_ci = '0;
  logic [NS-1:0] m_valid = '0;

  int tmr[NS] = '{default: 0};
  int dly[NS] = '{default: 1};
  bit [NS-1:0] req_en = '0;
  bit rnd_mode = 1'b0;
  bit ci_tbl_on = 1'b0;
  logic [CW-1:0] ci_tbl[4];

  // Row r's imaginary coordinate straight from the frame parameters.
  function automatic logic [CW-1:0] ci_of(int r);
    longint v;
    v = longint'($signed(m_iy)) + longint'(r) * longint'($signed(m_inc));
    return v[CW-1:0];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int g;
    phase_t ph;
    bit [NS-1:0] old_out;
    int old_next;
    g = -1; ph = m_ph; old_out = m_out; old_next = m_next;
    m_valid = '0;
    if (reset) begin
      m_ph = P_IDLE; m_out = '0; m_ptr = 0; m_next = 0; m_cc = 0; m_idx = 0;
      m_x0 = '0; m_ci = '0; m_ix = '0; m_iy = '0; m_inc = '0;
      return;
    end
    if (ph == P_DISP && m_next < ROWS && !start)
      for (int j = 0; j < NS; j++) begin
        int k;
        k = (m_ptr + j) % NS;
        if (g < 0 && row_req[k] && !m_out[k]) g = k;
      end
    if (start) begin
      m_ph = P_LOAD; m_ix = init_x; m_iy = init_y; m_inc = y_incr;
      m_next = 0; m_out = '0; m_ptr = 0; m_cc = 0;
    end else begin
      if (ph inside {P_LOAD, P_DISP, P_DRAIN} && m_cc < MAXCC) m_cc++;
      if (ph != P_LOAD) m_out = m_out & ~row_done;
      if (g >= 0) begin
        m_out[g] = 1'b1; m_valid[g] = 1'b1;
        m_idx = m_next; m_x0 = m_ix; m_ci = ci_of(m_next);
        m_next++; m_ptr = (g + 1) % NS;
      end
      case (ph)
        P_LOAD:  m_ph = P_DISP;
        P_DISP:  if (old_next == ROWS) m_ph = P_DRAIN;
        P_DRAIN: if (old_out == '0) m_ph = P_DONE;
        default: m_ph = ph;
      endcase
    end
  endtask

  // Solvers: request when enabled, finish a granted row after its delay.
  task automatic drive_solvers();
    logic [NS-1:0] d;
    d = '0;
    for (int i = 0; i < NS; i++) begin
      if (!(m_ph inside {P_DISP, P_DRAIN})) tmr[i] = 0;
      else if (tmr[i] > 0) begin
        tmr[i]--;
        if (tmr[i] == 0) d[i] = 1'b1;
      end
      if (m_valid[i]) tmr[i] = rnd_mode ? int'($urandom_range(1, 6)) : dly[i];
      row_req[i] = req_en[i] && (!rnd_mode || $urandom_range(0, 3) != 0);
    end
    row_done = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("row_valid", row_valid, m_valid);
    chk("row_index", row_index, m_idx);
    chk("row_x0", row_x0, m_x0);
    chk("row_ci", row_ci, m_ci);
    chk("flush", flush, m_ph == P_LOAD);
    chk("busy", busy, m_ph inside {P_LOAD, P_DISP, P_DRAIN});
    chk("done", done, m_ph == P_DONE);
    chk("cycle_count", cycle_count, m_cc);
    if (ci_tbl_on && row_valid != '0 && row_index < 4) chk("ci_table", row_ci, ci_tbl[row_index]);
    drive_solvers();
  endtask

  task automatic run_frame(string tag, int bound);
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < bound && m_ph != P_DONE; c++) step();
    chk(tag, done, 1);
  endtask

  initial begin
    int ng;
    reset = 1'b1; start = 1'b0; row_req = '0; row_done = '0;
    init_x = '0; init_y = '0; y_incr = '0;
    ci_tbl[0] = 27'h0100000; ci_tbl[1] = 27'h00FF000; ci_tbl[2] = 27'h00FE000; ci_tbl[3] = 27'h00FD000;

    step(); step();
    chk("reset_valid", row_valid, 0);
    chk("reset_cc", cycle_count, 0);
    reset = 1'b0;
    step();

    // Single solver, 3-cycle turnaround, descending imaginary axis.
    req_en = 4'b0001; dly[0] = 3; ci_tbl_on = 1'b1;
    init_x = 27'h7C00000; init_y = 27'h0100000; y_incr = -27'sh1000;
    run_frame("single_frame_done", 200);
    chk("single_frame_cc", cycle_count, 42);
    ci_tbl_on = 1'b0;
    step();

    // All four requesting; solver 2 finishes first and is regranted first.
    req_en = 4'b1111; dly = '{20, 20, 5, 20};
    init_x = 27'h0123456; init_y = 27'h7F00000; y_incr = 27'h0000800;
    run_frame("four_solver_done", 200);

    // Spurious row_done[1] on a solver holding no row.
    req_en = 4'b1101; dly = '{5, 5, 7, 3};
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 200 && m_ph != P_DONE; c++) begin
      step();
      if (c % 3 == 0) row_done[1] = 1'b1;
    end
    chk("spurious_done", done, 1);

    // Restart after five grants, with stale row_done during LOAD.
    req_en = 4'b1111; dly = '{4, 4, 4, 4};
    init_y = 27'h0200000;
    start = 1'b1; step(); start = 1'b0;
    ng = 0;
    for (int c = 0; c < 100 && ng < 5; c++) begin
      step();
      if (row_valid != '0) ng++;
    end
    chk("five_grants", ng, 5);
    init_y = 27'h0333333; y_incr = 27'h7FFF800;
    start = 1'b1; step(); start = 1'b0;
    chk("restart_flush", flush, 1);
    row_done = '1;
    step();
    chk("load_one_cycle", flush, 0);
    for (int c = 0; c < 200 && m_ph != P_DONE; c++) step();
    chk("restart_done", done, 1);

    // Reset in the middle of DRAIN, then a clean frame.
    dly = '{15, 15, 15, 15};
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 200 && m_ph != P_DRAIN; c++) step();
    chk("reached_drain", busy, 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_flush", flush, 0);
    dly = '{2, 3, 4, 5};
    run_frame("post_reset_frame", 200);

    // Long DRAIN: cycle counter saturates.
    dly = '{80, 2, 2, 2};
    run_frame("sat_frame", 300);
    chk("cc_saturated", cycle_count, MAXCC);

    // Randomized traffic, spurious dones and occasional restarts.
    rnd_mode = 1'b1;
    for (int f = 0; f < 8; f++) begin
      init_x = CW'($urandom); init_y = CW'($urandom); y_incr = CW'($urandom);
      start = 1'b1; step(); start = 1'b0;
      for (int c = 0; c < 400 && m_ph != P_DONE; c++) begin
        step();
        start = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 9) == 0) row_done = row_done | NS'($urandom);
      end
      start = 1'b0;
      chk("random_frame_done", done, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
